// File: rtl/seq_fp_multiplier.sv
// rtl/seq_fp_multiplier.sv - multi-cycle shift-add IEEE-754-style floating-point multiplier
module seq_fp_multiplier #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] input_a,
    input  logic [EXP_W+MAN_W:0] input_b,
    input  logic                 rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] output_z,
    output logic [3:0]           flags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int M     = MAN_W + 1;
    localparam int P     = 2 * M;
    localparam int EW    = EXP_W + 3;
    localparam int CNT_W = $clog2(M);

    localparam logic signed [EW-1:0] BIAS_S     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMIN       = EW'(2 - (1 << (EXP_W - 1)));
    localparam logic signed [EW-1:0] EMAX_FIELD = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_S      = EW'(1);
    localparam logic signed [EW-1:0] ZERO_S     = EW'(0);

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

    state_t                 state, state_nx;
    logic [W-1:0]           a_reg, b_reg;
    logic                   rm_reg;
    logic                   sign_reg;
    logic signed [EW-1:0]   exp_reg;
    logic [P-1:0]           mcand, prod;
    logic [M-1:0]           mplier;
    logic [CNT_W-1:0]       cnt;
    logic [M-1:0]           man;
    logic                   g_bit, r_bit, s_bit;
    logic [W-1:0]           z_reg;
    logic [3:0]             flags_reg;

    // Position of the most significant set bit, expressed as leading zeros.
    function automatic logic [EW-1:0] lead_zeros(input logic [M-1:0] v);
        logic [EW-1:0] n;
        n = '0;
        for (int i = 0; i < M; i++) begin
            if (v[i]) n = EW'(M - 1 - i);
        end
        return n;
    endfunction

    // Mantissa with hidden bit at the MSB and unbiased exponent; denormals are
    // left-normalised so the multiplier always sees a leading one.
    function automatic logic [M+EW-1:0] unpack_op(input logic [W-2:0] x);
        logic [EXP_W-1:0]     ef;
        logic [EW-1:0]        lz;
        logic [M-1:0]         m;
        logic signed [EW-1:0] e;
        ef = x[W-2:MAN_W];
        if (ef == '0) begin
            lz = lead_zeros({1'b0, x[MAN_W-1:0]});
            m  = {1'b0, x[MAN_W-1:0]} << lz;
            e  = EMIN - $signed(lz);
        end else begin
            m = {1'b1, x[MAN_W-1:0]};
            e = $signed({{(EW - EXP_W){1'b0}}, ef}) - BIAS_S;
        end
        return {m, e};
    endfunction

    logic [M-1:0]         ma, mb;
    logic signed [EW-1:0] ea, eb;
    assign {ma, ea} = unpack_op(a_reg[W-2:0]);
    assign {mb, eb} = unpack_op(b_reg[W-2:0]);

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_ab;
    assign a_nan   = (&a_reg[W-2:MAN_W]) & (|a_reg[MAN_W-1:0]);
    assign b_nan   = (&b_reg[W-2:MAN_W]) & (|b_reg[MAN_W-1:0]);
    assign a_inf   = (&a_reg[W-2:MAN_W]) & ~(|a_reg[MAN_W-1:0]);
    assign b_inf   = (&b_reg[W-2:MAN_W]) & ~(|b_reg[MAN_W-1:0]);
    assign a_zero  = ~(|a_reg[W-2:0]);
    assign b_zero  = ~(|b_reg[W-2:0]);
    assign sign_ab = a_reg[W-1] ^ b_reg[W-1];

    logic         is_special, is_nan_res;
    logic [W-1:0] spec_z;
    logic [3:0]   spec_flags;

    // Special-operand result: canonical qNaN, signed infinity or signed zero.
    always_comb begin
        is_nan_res = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        spec_flags = {is_nan_res, 3'b000};
        if (is_nan_res) begin
            spec_z = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
        end else if (a_inf | b_inf) begin
            spec_z = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_z = {sign_ab, {(W - 1){1'b0}}};
        end
    end

    logic [P-1:0]         pn, pd;
    logic signed [EW-1:0] en, en_d;
    logic [EW-1:0]        dsh;
    logic                 sh_sticky;

    // Put the hidden bit at the product MSB, then denormalise if the exponent is too small.
    always_comb begin
        if (prod[P-1]) begin
            pn = prod;
            en = exp_reg + ONE_S;
        end else begin
            pn = prod << 1;
            en = exp_reg;
        end
        pd        = pn;
        en_d      = en;
        sh_sticky = 1'b0;
        dsh       = '0;
        if (en < EMIN) begin
            dsh  = EMIN - en;
            en_d = EMIN;
            if (dsh >= EW'(P)) begin
                pd        = '0;
                sh_sticky = |pn;
            end else begin
                pd        = pn >> dsh;
                sh_sticky = |(pn & ~({P{1'b1}} << dsh));
            end
        end
    end

    logic [M:0]           mr;
    logic                 carry, inexact, round_up, ovf, tiny;
    logic [M-1:0]         mf;
    logic signed [EW-1:0] be;
    logic [W-1:0]         round_z;
    logic [3:0]           round_flags;

    // Apply the rounding mode and pack the final word with its exception flags.
    always_comb begin
        inexact  = g_bit | r_bit | s_bit;
        round_up = ~rm_reg & g_bit & (r_bit | s_bit | man[0]);
        mr       = {1'b0, man} + {{M{1'b0}}, round_up};
        carry    = mr[M];
        mf       = carry ? mr[M:1] : mr[M-1:0];
        be       = exp_reg + BIAS_S + (carry ? ONE_S : ZERO_S);
        ovf      = mf[M-1] & (be >= EMAX_FIELD);
        tiny     = ~mf[M-1];
        if (ovf) begin
            round_z     = rm_reg ? {sign_reg, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                 : {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            round_flags = 4'b0101;
        end else begin
            round_z     = {sign_reg, (mf[M-1] ? be[EXP_W-1:0] : {EXP_W{1'b0}}), mf[MAN_W-1:0]};
            round_flags = {1'b0, 1'b0, tiny & inexact, inexact};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = UNPACK;
            UNPACK:  state_nx = is_special ? DONE : MULT;
            MULT:    if (cnt == '0) state_nx = NORM;
            NORM:    state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers advanced by the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            rm_reg    <= 1'b0;
            sign_reg  <= 1'b0;
            exp_reg   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
            man       <= '0;
            g_bit     <= 1'b0;
            r_bit     <= 1'b0;
            s_bit     <= 1'b0;
            z_reg     <= '0;
            flags_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= input_a;
                        b_reg  <= input_b;
                        rm_reg <= rm;
                    end
                end
                UNPACK: begin
                    sign_reg <= sign_ab;
                    if (is_special) begin
                        z_reg     <= spec_z;
                        flags_reg <= spec_flags;
                    end else begin
                        mcand   <= {{M{1'b0}}, ma};
                        mplier  <= mb;
                        prod    <= '0;
                        exp_reg <= ea + eb;
                        cnt     <= CNT_W'(MAN_W);
                    end
                end
                MULT: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                NORM: begin
                    man     <= pd[P-1:P-M];
                    g_bit   <= pd[P-M-1];
                    r_bit   <= pd[P-M-2];
                    s_bit   <= (|pd[P-M-3:0]) | sh_sticky;
                    exp_reg <= en_d;
                end
                ROUND: begin
                    z_reg     <= round_z;
                    flags_reg <= round_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign output_z  = z_reg;
    assign flags     = flags_reg;
endmodule
